// File: rtl/snn_pkg.sv
// Types and helpers shared by the spiking-network blocks (synapse and neuron).
package snn_pkg;

  localparam int unsigned CURRENT_W = 8;

  typedef logic [CURRENT_W-1:0] current_t;

  function automatic current_t sat_add(current_t a, current_t b);
    logic [CURRENT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CURRENT_W] ? {CURRENT_W{1'b1}} : sum[CURRENT_W-1:0];
  endfunction

endpackage

// File: rtl/synapse_weight_bank.sv
// Per-input synaptic weight registers with a valid/ready write port.
module synapse_weight_bank #(
  parameter int unsigned N_INPUTS    = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned WEIGHT_INIT = 1,
  parameter int unsigned AW          = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wt_valid,
  output logic                  wt_ready,
  input  logic [AW-1:0]         wt_addr,
  input  logic [W-1:0]          wt_data,
  output logic [N_INPUTS*W-1:0] weights
);

  logic         ready_q;
  logic         accept;
  logic [W-1:0] w_q [N_INPUTS];

  assign accept   = wt_valid && ready_q;
  assign wt_ready = ready_q;

  // Out-of-range addresses match no entry, so the write is accepted and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      for (int i = 0; i < int'(N_INPUTS); i++) w_q[i] <= W'(WEIGHT_INIT);
    end else begin
      ready_q <= !accept;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
        if (accept && wt_addr == AW'(i)) w_q[i] <= wt_data;
      end
    end
  end

  always_comb begin
    weights = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) weights[i*W +: W] = w_q[i];
  end

endmodule

// File: rtl/lif_synapse.sv
// Current-based synapse: weighted spike-edge accumulation with periodic exponential decay.
module lif_synapse
  import snn_pkg::*;
#(
  parameter int unsigned N_INPUTS     = 4,
  parameter int unsigned W            = CURRENT_W,
  parameter int unsigned DECAY_SHIFT  = 2,
  parameter int unsigned DECAY_PERIOD = 4,
  parameter int unsigned WEIGHT_INIT  = 1,
  localparam int unsigned AW          = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                wt_valid,
  output logic                wt_ready,
  input  logic [AW-1:0]       wt_addr,
  input  logic [W-1:0]        wt_data,
  output logic [W-1:0]        isyn,
  output logic                saturated
);

  localparam int unsigned SW = W + $clog2(N_INPUTS);
  localparam int unsigned NW = SW + 1;
  localparam int unsigned CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [NW-1:0] MAX_CUR = NW'({W{1'b1}});

  logic [N_INPUTS*W-1:0] weights;
  logic [N_INPUTS-1:0]   spike_q, fired;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [W-1:0]          isyn_q, isyn_d, decay_amt, decayed;
  logic                  sat_q, sat_d;
  logic [SW-1:0]         wsum;
  logic [NW-1:0]         total;

  synapse_weight_bank #(
    .N_INPUTS    (N_INPUTS),
    .W           (W),
    .WEIGHT_INIT (WEIGHT_INIT),
    .AW          (AW)
  ) u_weights (
    .clk      (clk),
    .rst_n    (rst_n),
    .wt_valid (wt_valid),
    .wt_ready (wt_ready),
    .wt_addr  (wt_addr),
    .wt_data  (wt_data),
    .weights  (weights)
  );

  always_comb begin
    fired = spike_in & ~spike_q;
    tick  = (cnt_q == CW'(DECAY_PERIOD - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Force a minimum step of 1 so small currents still drain to zero.
    decay_amt = isyn_q >> DECAY_SHIFT;
    if (decay_amt == '0 && isyn_q != '0) decay_amt = W'(1);
    decayed = tick ? isyn_q - decay_amt : isyn_q;

    wsum = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      if (fired[i]) wsum = wsum + SW'(weights[i*W +: W]);
    end

    total  = NW'(decayed) + NW'(wsum);
    sat_d  = (total > MAX_CUR);
    isyn_d = sat_d ? {W{1'b1}} : total[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      cnt_q   <= '0;
      isyn_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      spike_q <= spike_in;
      cnt_q   <= cnt_d;
      isyn_q  <= isyn_d;
      sat_q   <= sat_d;
    end
  end

  assign isyn      = isyn_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_lif_synapse.sv
// Directed bench: stimulus queues hand-computed expectations keyed by edge count; a monitor checks.
module tb_lif_synapse;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] spike_in = '0;
  logic       wt_valid = 1'b0;
  logic       wt_ready;
  logic [1:0] wt_addr = '0;
  logic [7:0] wt_data = '0;
  logic [7:0] isyn;
  logic       saturated;

  lif_synapse dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .wt_valid  (wt_valid),
    .wt_ready  (wt_ready),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .isyn      (isyn),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; ticks land on multiples of 4.
  int edge_n = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  typedef struct {
    int         due;   // -1: check right after the asynchronous reset assertion
    logic [7:0] isyn;
    logic       sat;
    logic       rdy;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input int due, input int cur, input bit sat, input bit rdy,
                      input string name);
    exp_t e;
    e.due  = due;
    e.isyn = 8'(cur);
    e.sat  = sat;
    e.rdy  = rdy;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (isyn !== e.isyn || saturated !== e.sat || wt_ready !== e.rdy) begin
      errors++;
      $display("FAIL %s: got isyn=%0d sat=%b rdy=%b, expected isyn=%0d sat=%b rdy=%b",
               e.name, isyn, saturated, wt_ready, e.isyn, e.sat, e.rdy);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].due >= 0 && exp_q[0].due <= edge_n) begin
          e = exp_q.pop_front();
          if (e.due < edge_n) begin
            checks++;
            errors++;
            $display("FAIL %s: edge %0d passed unchecked, now at edge %0d", e.name, e.due, edge_n);
          end else begin
            compare(e);
          end
        end
      end
    end
  end

  initial begin : reset_monitor
    forever begin
      @(negedge rst_n);
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == -1) compare(exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #5000;
    $display("FAIL watchdog: simulation did not complete, edge=%0d pending=%0d", edge_n,
             exp_q.size());
    $fatal(1);
  end

  // Return at the falling edge where edge_n == n; inputs set now are sampled at edge n+1.
  task automatic at(input int n);
    @(negedge clk);
    while (edge_n < n) @(negedge clk);
    if (edge_n != n) begin
      $display("FAIL sequencing: reached edge %0d, wanted %0d", edge_n, n);
      $fatal(1);
    end
  endtask

  task automatic write(input int addr, input int data);
    wt_valid = 1'b1;
    wt_addr  = 2'(addr);
    wt_data  = 8'(data);
  endtask

  initial begin : stimulus
    push(0, 0, 0, 1, "reset_state");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Weight 1 from reset, single-cycle pulse; decays to 0 on the first tick.
    at(0);  spike_in = 4'b0001;
    push(1, 1, 0, 1, "reset_weight_add");
    push(3, 1, 0, 1, "hold_before_tick");
    push(4, 0, 0, 1, "min_decay_to_zero");
    push(6, 0, 0, 1, "stays_zero");
    at(1);  spike_in = '0;

    at(6);  write(0, 100);
    push(7, 0, 0, 0, "ready_low_after_accept");
    push(8, 0, 0, 1, "ready_back_high");
    at(7);  wt_valid = 1'b0;
    at(8);  spike_in = 4'b0001;
    push(9, 100, 0, 1, "add_w100");
    push(11, 100, 0, 1, "no_decay_off_tick");
    push(12, 75, 0, 1, "decay_75");
    push(16, 57, 0, 1, "decay_57");
    push(20, 43, 0, 1, "decay_43");
    push(24, 33, 0, 1, "decay_33");
    at(9);  spike_in = '0;

    // Write and spike on input 2 in the same cycle: old weight 1 is used.
    at(24); write(2, 50); spike_in = 4'b0100;
    push(25, 34, 0, 0, "collision_old_weight");
    push(27, 84, 0, 1, "collision_new_weight");
    push(28, 63, 0, 1, "decay_84");
    at(25); wt_valid = 1'b0; spike_in = '0;
    at(26); spike_in = 4'b0100;
    at(27); spike_in = '0;

    at(28); write(0, 200);
    push(29, 63, 0, 0, "ready_low_wr0");
    at(29); wt_valid = 1'b0;
    at(30); write(1, 200);
    at(31); wt_valid = 1'b0;
    at(32); write(2, 200);
    at(33); wt_valid = 1'b0;
    at(34); write(3, 200);
    at(35); wt_valid = 1'b0;
    push(36, 36, 0, 1, "pre_saturation");
    at(36); spike_in = 4'b1111;
    push(37, 255, 1, 1, "saturate_clip");
    push(38, 255, 0, 1, "saturated_clears");
    push(40, 192, 0, 1, "decay_from_full");
    at(37); spike_in = '0;

    // Held level counts once; a fresh edge adds again.
    at(40); write(1, 10);
    push(41, 192, 0, 0, "ready_low_wr1");
    at(41); wt_valid = 1'b0;
    at(42); spike_in = 4'b0010;
    push(43, 202, 0, 1, "held_first_add");
    push(44, 152, 0, 1, "held_tick");
    push(47, 152, 0, 1, "held_single_add");
    push(48, 114, 0, 1, "held_released_tick");
    push(49, 124, 0, 1, "re_edge_add");
    at(47); spike_in = '0;
    at(48); spike_in = 4'b0010;
    at(49); spike_in = '0; write(3, 7);
    push(50, 124, 0, 0, "pending_setup");

    // New write held pending while ready is low, then asynchronous reset.
    at(50); write(0, 9);
    push(-1, 0, 0, 1, "async_reset_immediate");
    #2 rst_n = 1'b0;
    #3 wt_valid = 1'b0;
    push(0, 0, 0, 1, "reset_release_state");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    at(0);  spike_in = 4'b1111;
    push(1, 4, 0, 1, "weights_reinit");
    push(4, 3, 0, 1, "decay_after_reinit");
    at(1);  spike_in = '0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
